// File: rtl/icache_data_ram_ways.sv
// icache_data_ram_ways: multi-way instruction-cache data store.
// Every way is read in parallel with one cycle of latency so fetch can mux by
// tag hit; a line-fill sequencer writes one line into one way, critical word
// first, wrapping inside the line.

// One way of storage: one write port, one registered read port.
module icache_data_way #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int WRITE_FIRST = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic              bypass;

  // Same-address write forwarded to the read port only in write-first mode.
  assign bypass = (WRITE_FIRST != 0) && we && (waddr == raddr);

  // Array write; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; holds its value while no read is requested.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)  rdata <= '0;
    else if (re) rdata <= bypass ? wdata : mem[raddr];
  end

endmodule

module icache_data_ram_ways #(
  parameter int WAYS        = 2,
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 32,
  parameter int LINE_W      = 3,
  parameter int WRITE_FIRST = 0,
  localparam int IDX_W      = ADDR_W - LINE_W,
  localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   rd_i,
  input  logic [ADDR_W-1:0]      rd_addr_i,
  output logic [WAYS*DATA_W-1:0] data_o,
  output logic                   rd_valid_o,
  input  logic                   fill_start_i,
  input  logic [WAY_W-1:0]       fill_way_i,
  input  logic [IDX_W-1:0]       fill_line_i,
  input  logic [LINE_W-1:0]      fill_offset_i,
  input  logic                   fill_valid_i,
  input  logic [DATA_W-1:0]      fill_data_i,
  output logic                   fill_ready_o,
  input  logic                   fill_abort_i,
  output logic                   fill_busy_o,
  output logic                   fill_done_o
);

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t                        state;
  logic [LINE_W:0]               cnt;
  logic [WAY_W-1:0]              fill_way;
  logic [IDX_W-1:0]              fill_line;
  logic [LINE_W-1:0]             fill_off;
  logic                          done_q;
  logic                          rd_vld_q;

  logic                          accept;
  logic                          last_beat;
  logic [LINE_W-1:0]             wr_off;
  logic [ADDR_W-1:0]             wr_addr;
  logic [WAYS-1:0][DATA_W-1:0]   rd_data;

  // Ready depends on state alone so the producer never sees a comb loop.
  assign fill_ready_o = (state == S_FILL);
  assign fill_busy_o  = (state == S_FILL);
  assign fill_done_o  = done_q;
  assign rd_valid_o   = rd_vld_q;
  assign data_o       = rd_data;

  // A beat presented together with abort is dropped.
  assign accept    = fill_valid_i & fill_ready_o & ~fill_abort_i;
  assign last_beat = (cnt[LINE_W-1:0] == {LINE_W{1'b1}});
  // Offset arithmetic truncates to LINE_W bits, giving the in-line wrap.
  assign wr_off    = fill_off + cnt[LINE_W-1:0];
  assign wr_addr   = {fill_line, wr_off};

  // Fill sequencer: capture target on start, count beats, pulse done after last.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= S_IDLE;
      cnt       <= '0;
      fill_way  <= '0;
      fill_line <= '0;
      fill_off  <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fill_start_i) begin
            fill_way  <= fill_way_i;
            fill_line <= fill_line_i;
            fill_off  <= fill_offset_i;
            cnt       <= '0;
            state     <= S_FILL;
          end
        end
        S_FILL: begin
          if (fill_abort_i) begin
            state <= S_IDLE;
          end else if (accept) begin
            cnt <= cnt + 1'b1;
            if (last_beat) begin
              state  <= S_IDLE;
              done_q <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read-valid tracks the request one cycle later.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) rd_vld_q <= 1'b0;
    else        rd_vld_q <= rd_i;
  end

  // One storage instance per way; out-of-range fill ways match no instance.
  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_data_way #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .WRITE_FIRST (WRITE_FIRST)
    ) u_way (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .we    (accept && (fill_way == WAY_W'(w))),
      .waddr (wr_addr),
      .wdata (fill_data_i),
      .re    (rd_i),
      .raddr (rd_addr_i),
      .rdata (rd_data[w])
    );
  end

endmodule

// File: tb/tb_icache_data_ram_ways.sv
// Directed bench for icache_data_ram_ways: two instances (read-first and
// write-first) share one stimulus stream; expected values are hand-derived.
module tb_icache_data_ram_ways;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd;
  logic [9:0]  rd_addr;
  logic        fill_start;
  logic [0:0]  fill_way;
  logic [6:0]  fill_line;
  logic [2:0]  fill_off;
  logic        fill_valid;
  logic [31:0] fill_data;
  logic        fill_abort;

  logic [63:0] d0, d1;
  logic        rv0, rv1, rdy0, rdy1, busy0, busy1, done0, done1;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  icache_data_ram_ways #(.WAYS(2), .ADDR_W(10), .DATA_W(32), .LINE_W(3), .WRITE_FIRST(0)) dut0 (
    .clk_i(clk), .rst_i(rst_n), .rd_i(rd), .rd_addr_i(rd_addr), .data_o(d0), .rd_valid_o(rv0),
    .fill_start_i(fill_start), .fill_way_i(fill_way), .fill_line_i(fill_line),
    .fill_offset_i(fill_off), .fill_valid_i(fill_valid), .fill_data_i(fill_data),
    .fill_ready_o(rdy0), .fill_abort_i(fill_abort), .fill_busy_o(busy0), .fill_done_o(done0));

  icache_data_ram_ways #(.WAYS(2), .ADDR_W(10), .DATA_W(32), .LINE_W(3), .WRITE_FIRST(1)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .rd_i(rd), .rd_addr_i(rd_addr), .data_o(d1), .rd_valid_o(rv1),
    .fill_start_i(fill_start), .fill_way_i(fill_way), .fill_line_i(fill_line),
    .fill_offset_i(fill_off), .fill_valid_i(fill_valid), .fill_data_i(fill_data),
    .fill_ready_o(rdy1), .fill_abort_i(fill_abort), .fill_busy_o(busy1), .fill_done_o(done1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] way_of(input logic [63:0] d, input int w);
    return d[w*32 +: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full 8-beat fill at one beat per cycle, checking handshake and done pulse.
  task automatic do_fill(input logic w, input logic [6:0] ln, input logic [2:0] off,
                         input logic [31:0] base);
    fill_start = 1'b1; fill_way = w; fill_line = ln; fill_off = off;
    tick();
    fill_start = 1'b0;
    chk("fill_ready_up", 64'(rdy0), 64'd1);
    chk("fill_busy_up", 64'(busy0), 64'd1);
    for (int k = 0; k < 8; k++) begin
      fill_valid = 1'b1; fill_data = base + 32'(k);
      tick();
    end
    fill_valid = 1'b0;
    chk("fill_done", 64'(done0), 64'd1);
    chk("fill_done_wf", 64'(done1), 64'd1);
    chk("fill_busy_end", 64'(busy0), 64'd0);
    tick();
    chk("fill_done_end", 64'(done0), 64'd0);
  endtask

  // Single read; expected way word for both instances.
  task automatic rd_chk(input string tag, input logic [9:0] a, input int w,
                        input logic [31:0] e0, input logic [31:0] e1);
    rd = 1'b1; rd_addr = a;
    tick();
    rd = 1'b0;
    chk(tag, 64'(way_of(d0, w)), 64'(e0));
    chk({tag, "_wf"}, 64'(way_of(d1, w)), 64'(e1));
    chk({tag, "_vld"}, 64'(rv0), 64'd1);
  endtask

  initial begin
    int acc, cyc, ndone;
    logic busy_ok;

    rst_n = 1'b0; rd = 1'b0; rd_addr = '0; fill_start = 1'b0; fill_way = '0;
    fill_line = '0; fill_off = '0; fill_valid = 1'b0; fill_data = '0; fill_abort = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", d0, 64'd0);
    chk("rst_rd_valid", 64'(rv0), 64'd0);
    chk("rst_ready", 64'(rdy0), 64'd0);
    chk("rst_busy", 64'(busy0), 64'd0);
    chk("rst_done", 64'(done0), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic fill and read back: way 1 line 5 -> 0x28..0x2F
    do_fill(1'b1, 7'd5, 3'd0, 32'h100);
    for (int k = 0; k < 8; k++)
      rd_chk("basic_rd", 10'h28 + 10'(k), 1, 32'h100 + 32'(k), 32'h100 + 32'(k));
    tick();
    chk("rd_valid_idle", 64'(rv0), 64'd0);
    chk("data_hold", 64'(way_of(d0, 1)), 64'h107);

    // Wrap-around: way 0 line 2 offset 6, beat k lands at offset (6+k)&7
    do_fill(1'b0, 7'd2, 3'd6, 32'hA0);
    for (int k = 0; k < 8; k++)
      rd_chk("wrap_rd", 10'h10 + 10'((6 + k) % 8), 0, 32'hA0 + 32'(k), 32'hA0 + 32'(k));

    // Back-pressure: valid 1,0,0,1,0,0,... into way 1 line 7
    fill_start = 1'b1; fill_way = 1'b1; fill_line = 7'd7; fill_off = 3'd0;
    tick();
    fill_start = 1'b0;
    acc = 0; cyc = 0; ndone = 0; busy_ok = 1'b1;
    while (acc < 8 && cyc < 100) begin
      fill_valid = (cyc % 3 == 0);
      fill_data  = 32'hC00 + 32'(acc);
      tick();
      if (fill_valid) acc++;
      if (acc < 8 && busy0 !== 1'b1) busy_ok = 1'b0;
      if (done0 === 1'b1) ndone++;
      cyc++;
    end
    fill_valid = 1'b0;
    repeat (3) begin
      tick();
      if (done0 === 1'b1) ndone++;
    end
    chk("bp_beats", 64'(acc), 64'd8);
    chk("bp_busy", 64'(busy_ok), 64'd1);
    chk("bp_done_cnt", 64'(ndone), 64'd1);
    for (int k = 0; k < 8; k++)
      rd_chk("bp_rd", 10'h38 + 10'(k), 1, 32'hC00 + 32'(k), 32'hC00 + 32'(k));

    // Abort after 3 beats, with a beat presented in the abort cycle
    do_fill(1'b0, 7'd3, 3'd0, 32'hD00);
    fill_start = 1'b1; fill_way = 1'b0; fill_line = 7'd3; fill_off = 3'd0;
    tick();
    fill_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      fill_valid = 1'b1; fill_data = 32'hE00 + 32'(k);
      tick();
    end
    fill_data = 32'hE03; fill_abort = 1'b1;
    tick();
    fill_valid = 1'b0; fill_abort = 1'b0;
    chk("abort_busy", 64'(busy0), 64'd0);
    chk("abort_ready", 64'(rdy0), 64'd0);
    chk("abort_done", 64'(done0), 64'd0);
    tick();
    chk("abort_done_next", 64'(done0), 64'd0);
    rd_chk("abort_w0", 10'h18, 0, 32'hE00, 32'hE00);
    rd_chk("abort_w1", 10'h19, 0, 32'hE01, 32'hE01);
    rd_chk("abort_w2", 10'h1A, 0, 32'hE02, 32'hE02);
    rd_chk("abort_w3", 10'h1B, 0, 32'hD03, 32'hD03);

    // Collision at 0x12 way 0: old 0xAAAA, new 0x5555; way 1 holds 0xB002
    do_fill(1'b0, 7'd2, 3'd0, 32'hAAA8);
    do_fill(1'b1, 7'd2, 3'd0, 32'hB000);
    fill_start = 1'b1; fill_way = 1'b0; fill_line = 7'd2; fill_off = 3'd2;
    tick();
    fill_start = 1'b0;
    fill_valid = 1'b1; fill_data = 32'h5555; rd = 1'b1; rd_addr = 10'h12;
    tick();
    rd = 1'b0; fill_valid = 1'b0; fill_abort = 1'b1;
    chk("coll_rf", 64'(way_of(d0, 0)), 64'hAAAA);
    chk("coll_wf", 64'(way_of(d1, 0)), 64'h5555);
    chk("coll_other_rf", 64'(way_of(d0, 1)), 64'hB002);
    chk("coll_other_wf", 64'(way_of(d1, 1)), 64'hB002);
    tick();
    fill_abort = 1'b0;
    chk("coll_abort_idle", 64'(busy0), 64'd0);
    rd_chk("coll_after", 10'h12, 0, 32'h5555, 32'h5555);

    // Start during FILL is ignored: target stays way 1 line 4 offset 0
    fill_start = 1'b1; fill_way = 1'b1; fill_line = 7'd4; fill_off = 3'd0;
    tick();
    fill_start = 1'b0;
    for (int k = 0; k < 8; k++) begin
      fill_valid = 1'b1; fill_data = 32'hF00 + 32'(k);
      if (k == 2) begin
        fill_start = 1'b1; fill_way = 1'b0; fill_line = 7'd6; fill_off = 3'd3;
      end else begin
        fill_start = 1'b0;
      end
      tick();
    end
    fill_valid = 1'b0; fill_start = 1'b0;
    chk("ign_start_done", 64'(done0), 64'd1);
    for (int k = 0; k < 8; k++)
      rd_chk("ign_start_rd", 10'h20 + 10'(k), 1, 32'hF00 + 32'(k), 32'hF00 + 32'(k));

    // Reset at beat 4 of a fill: outputs drop at once
    fill_start = 1'b1; fill_way = 1'b0; fill_line = 7'd1; fill_off = 3'd0;
    tick();
    fill_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      fill_valid = 1'b1; fill_data = 32'h600 + 32'(k);
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy0), 64'd0);
    chk("midrst_ready", 64'(rdy0), 64'd0);
    chk("midrst_done", 64'(done0), 64'd0);
    chk("midrst_data", d0, 64'd0);
    fill_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    chk("postrst_busy", 64'(busy0), 64'd0);
    do_fill(1'b0, 7'd1, 3'd0, 32'h700);
    rd_chk("postrst_w0", 10'h08, 0, 32'h700, 32'h700);
    rd_chk("postrst_w3", 10'h0B, 0, 32'h703, 32'h703);
    rd_chk("postrst_w7", 10'h0F, 0, 32'h707, 32'h707);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/icache_data_ram_ways.md
# icache_data_ram_ways

Parametrised, multi-way instruction-cache data store with an integrated line-fill sequencer. A single registered read returns the selected word from every way in parallel, so the fetch stage can mux by tag hit. A fill port accepts a burst of one cache line into a chosen way, critical word first, with wrap-around inside the line. It sits between the icache tag/control logic and the fetch pipeline and replaces the fixed 1-way, 4 KB single-port data RAM.

## Interface
- `WAYS`, default 2: number of ways, 1..8.
- `ADDR_W`, default 10: word-address width per way (depth = 2^ADDR_W words).
- `DATA_W`, default 32: word width.
- `LINE_W`, default 3: log2 of words per line (1..ADDR_W-1).
- `WRITE_FIRST`, default 0: 0 = read-first, 1 = write-first bypass on a same-address collision.

Ports (IDX_W = ADDR_W-LINE_W; WAY_W = max(1, clog2(WAYS))):
- `clk_i`, in, 1: clock; all logic on the rising edge.
- `rst_i`, in, 1: reset, asynchronous, active-low.
- `rd_i`, in, 1: read request.
- `rd_addr_i`, in, ADDR_W: read word address.
- `data_o`, out, WAYS*DATA_W: read data; way w occupies bits [w*DATA_W +: DATA_W].
- `rd_valid_o`, out, 1: `data_o` updated this cycle.
- `fill_start_i`, in, 1: begin a line fill.
- `fill_way_i`, in, WAY_W: target way, sampled on start.
- `fill_line_i`, in, IDX_W: target line index, sampled on start.
- `fill_offset_i`, in, LINE_W: first (critical) word offset, sampled on start.
- `fill_valid_i`, in, 1: fill beat valid.
- `fill_data_i`, in, DATA_W: fill beat data.
- `fill_ready_o`, out, 1: sequencer accepting beats.
- `fill_abort_i`, in, 1: terminate the fill in progress.
- `fill_busy_o`, out, 1: fill in progress.
- `fill_done_o`, out, 1: one-cycle pulse after the last beat is written.

## Operation
- Storage: WAYS independent arrays of 2^ADDR_W x DATA_W, each with one write port and one read port. Reset does not clear contents.
- Read: when `rd_i`=1, all ways are read at `rd_addr_i`.
  - `data_o` and `rd_valid_o`=1 are registered the next cycle.
  - When `rd_i`=0, `data_o` holds its previous value and `rd_valid_o`=0.
- Fill FSM has two states, IDLE and FILL.
  - IDLE -> FILL on `fill_start_i`. On entry, capture way, line and offset; clear beat counter `cnt` (LINE_W+1 bits).
  - In FILL, `fill_ready_o`=1 and `fill_busy_o`=1.
  - A beat is accepted when `fill_valid_i` & `fill_ready_o` & !`fill_abort_i`.
  - An accepted beat writes `fill_data_i` to way `fill_way` at address {`fill_line`, (`fill_offset`+`cnt[LINE_W-1:0]`) mod 2^LINE_W}, then `cnt`++.
  - Accepting beat number 2^LINE_W-1 (the last) moves FILL -> IDLE, with `fill_done_o`=1 in the following cycle.
  - `fill_abort_i` in FILL moves to IDLE. Any beat presented that cycle is discarded, `fill_done_o` does not pulse, and words already written remain.
- `fill_start_i` while in FILL is ignored.
- In IDLE, `fill_abort_i` is ignored; if `fill_start_i` and `fill_abort_i` arrive together in IDLE, the start is taken.
- `fill_way_i` >= WAYS: the fill runs its full handshake but no array is written.
- Collision (read and write to the same way and address in the same cycle):
  - `WRITE_FIRST`=0: `data_o` for that way returns the old word.
  - `WRITE_FIRST`=1: it returns `fill_data_i`.
  - Other ways are unaffected either way.

## Timing
- Read latency: 1 cycle. Reads are accepted every cycle, including during a fill.
- Fill throughput: 1 beat/cycle; a minimum fill takes 2^LINE_W cycles after the start cycle.
- `fill_ready_o` is combinational from FSM state only. It is first high the cycle after `fill_start_i` and low the cycle after the last beat or after an abort.
- `fill_done_o` goes high exactly one cycle after the last accepted beat. A new `fill_start_i` is legal in that same cycle.
- Reset values: `data_o`=0, `rd_valid_o`=0, `fill_ready_o`=0, `fill_busy_o`=0, `fill_done_o`=0, FSM=IDLE, `cnt`=0.
- Reset asserted mid-fill: outputs drop immediately. Partial line contents remain; the control logic must invalidate the tag.

## Test plan
- Reset and read: hold `rst_i`=0, check all outputs are 0. Release, fill way 1 line 5 with data 0x100+k, then read address 0x28..0x2F. Expect way-1 `data_o` = 0x100..0x107 one cycle after each `rd_i`, with `rd_valid_o`=1.
- Wrap-around: fill way 0 line 2 with offset 6 and beats A0..A7. Expect word offsets 6,7,0,1,...,5 to hold A0..A7, and `fill_done_o` to pulse 1 cycle after A7.
- Back-pressure: toggle `fill_valid_i` 1,0,0,1,... across 8 beats. Expect exactly 8 writes, `fill_busy_o`=1 throughout, and `fill_done_o` once.
- Abort: abort after 3 beats, with a beat presented in the abort cycle. Expect 3 words written, the 4th untouched, `fill_done_o`=0, and IDLE on the next cycle.
- Collision: read and write address 0x12 of way 0 in the same cycle (old 0xAAAA, new 0x5555). Expect 0xAAAA for `WRITE_FIRST`=0 and 0x5555 for `WRITE_FIRST`=1. Way 1 is unchanged.
- Ignored starts and reset mid-fill: assert `fill_start_i` during FILL and expect no re-capture. Assert `rst_i`=0 at beat 4 and expect `fill_busy_o`=0 immediately; after reset, expect normal fills.
